ones_window_stats: RTL and testbench



---
 rtl/ones_window_stats.sv | 156 +++++++++++++++
 tb/tb_ones_window_stats.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_window_stats.sv
// ones_window_stats: groups WINDOW strobed ones-counts into a window and
// publishes the sum, max, min and the number of "high" samples for it.
// Results are registered and announced with a single-cycle out_valid pulse.
module ones_window_stats #(
    parameter int WINDOW = 8,
    parameter int THRESH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  count,
    input  logic        clear,
    output logic        busy,
    output logic        out_valid,
    output logic [11:0] win_sum,
    output logic [3:0]  win_max,
    output logic [3:0]  win_min,
    output logic [7:0]  hi_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);
    localparam logic [3:0] THRESH_W = 4'(THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] accSum_q, accSum_d;
    logic [3:0]  accMax_q, accMax_d;
    logic [3:0]  accMin_q, accMin_d;
    logic [7:0]  accHi_q, accHi_d;
    logic [7:0]  idx_q, idx_d;
    logic [11:0] winSum_q, winSum_d;
    logic [3:0]  winMax_q, winMax_d;
    logic [3:0]  winMin_q, winMin_d;
    logic [7:0]  hiCnt_q, hiCnt_d;
    logic        outValid_q;
    logic        busy_q;

    logic        isHigh;
    logic [11:0] nextSum;
    logic [3:0]  nextMax;
    logic [3:0]  nextMin;
    logic [7:0]  nextHi;

    // Running values the accumulators take if the current sample is folded in
    always_comb begin
        isHigh  = (count >= THRESH_W);
        nextSum = accSum_q + {8'd0, count};
        nextMax = (count > accMax_q) ? count : accMax_q;
        nextMin = (count < accMin_q) ? count : accMin_q;
        nextHi  = accHi_q + {7'd0, isHigh};
    end

    // Next-state and accumulator update; clear wins over in_valid, and a
    // sample arriving during DONE opens the next window so none is dropped
    always_comb begin
        state_d  = state_q;
        accSum_d = accSum_q;
        accMax_d = accMax_q;
        accMin_d = accMin_q;
        accHi_d  = accHi_q;
        idx_d    = idx_q;
        winSum_d = winSum_q;
        winMax_d = winMax_q;
        winMin_d = winMin_q;
        hiCnt_d  = hiCnt_q;

        case (state_q)
            ACC: begin
                if (clear) begin
                    state_d  = IDLE;
                    accSum_d = 12'd0;
                    accMax_d = 4'd0;
                    accMin_d = 4'd0;
                    accHi_d  = 8'd0;
                    idx_d    = 8'd0;
                end else if (in_valid) begin
                    accSum_d = nextSum;
                    accMax_d = nextMax;
                    accMin_d = nextMin;
                    accHi_d  = nextHi;
                    idx_d    = idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        winSum_d = nextSum;
                        winMax_d = nextMax;
                        winMin_d = nextMin;
                        hiCnt_d  = nextHi;
                        state_d  = DONE;
                    end
                end
            end
            default: begin
                if (clear) begin
                    state_d  = IDLE;
                    accSum_d = 12'd0;
                    accMax_d = 4'd0;
                    accMin_d = 4'd0;
                    accHi_d  = 8'd0;
                    idx_d    = 8'd0;
                end else if (in_valid) begin
                    state_d  = ACC;
                    accSum_d = {8'd0, count};
                    accMax_d = count;
                    accMin_d = count;
                    accHi_d  = {7'd0, isHigh};
                    idx_d    = 8'd1;
                end else begin
                    state_d  = IDLE;
                end
            end
        endcase
    end

    // State, accumulators, published results and decoded status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            accSum_q   <= 12'd0;
            accMax_q   <= 4'd0;
            accMin_q   <= 4'd0;
            accHi_q    <= 8'd0;
            idx_q      <= 8'd0;
            winSum_q   <= 12'd0;
            winMax_q   <= 4'd0;
            winMin_q   <= 4'd0;
            hiCnt_q    <= 8'd0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            accSum_q   <= accSum_d;
            accMax_q   <= accMax_d;
            accMin_q   <= accMin_d;
            accHi_q    <= accHi_d;
            idx_q      <= idx_d;
            winSum_q   <= winSum_d;
            winMax_q   <= winMax_d;
            winMin_q   <= winMin_d;
            hiCnt_q    <= hiCnt_d;
            outValid_q <= (state_d == DONE);
            busy_q     <= (state_d == ACC);
        end
    end

    assign busy      = busy_q;
    assign out_valid = outValid_q;
    assign win_sum   = winSum_q;
    assign win_max   = winMax_q;
    assign win_min   = winMin_q;
    assign hi_cnt    = hiCnt_q;

endmodule

// File: tb/tb_ones_window_stats.sv
// tb_ones_window_stats: scoreboard bench for ones_window_stats with a small
// WINDOW=4/THRESH=8 instance and a full-size WINDOW=255/THRESH=0 instance.
module tb_ones_window_stats;

    typedef struct packed {
        logic [11:0] sum;
        logic [3:0]  mx;
        logic [3:0]  mn;
        logic [7:0]  hi;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        inValid4 = 1'b0;
    logic [3:0]  count4 = 4'd0;
    logic        clear4 = 1'b0;
    logic        busy4;
    logic        outValid4;
    logic [11:0] winSum4;
    logic [3:0]  winMax4;
    logic [3:0]  winMin4;
    logic [7:0]  hiCnt4;

    logic        inValid255 = 1'b0;
    logic [3:0]  count255 = 4'd0;
    logic        clear255 = 1'b0;
    logic        busy255;
    logic        outValid255;
    logic [11:0] winSum255;
    logic [3:0]  winMax255;
    logic [3:0]  winMin255;
    logic [7:0]  hiCnt255;

    int total = 0;
    int bad = 0;
    int pulses255 = 0;

    result_t q4[$];
    result_t q255[$];

    int          modelIdx = 0;
    logic [11:0] modelSum = 12'd0;
    logic [3:0]  modelMax = 4'd0;
    logic [3:0]  modelMin = 4'd0;
    logic [7:0]  modelHi = 8'd0;
    logic        expOut4 = 1'b0;
    logic        expBusy4 = 1'b0;

    ones_window_stats #(.WINDOW(4), .THRESH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .count(count4),
        .clear(clear4), .busy(busy4), .out_valid(outValid4),
        .win_sum(winSum4), .win_max(winMax4), .win_min(winMin4), .hi_cnt(hiCnt4)
    );

    ones_window_stats #(.WINDOW(255), .THRESH(0)) dut255 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid255), .count(count255),
        .clear(clear255), .busy(busy255), .out_valid(outValid255),
        .win_sum(winSum255), .win_max(winMax255), .win_min(winMin255), .hi_cnt(hiCnt255)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus to the WINDOW=4 instance; the reference model
    // advances on the same edge and pushes a result when a window completes
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic clr);
        result_t r;
        inValid4 = v;
        count4   = c;
        clear4   = clr;
        @(posedge clk);
        expOut4 = 1'b0;
        if (clr) begin
            modelIdx = 0;
        end else if (v) begin
            if (modelIdx == 0) begin
                modelSum = {8'd0, c};
                modelMax = c;
                modelMin = c;
                modelHi  = (c >= 4'd8) ? 8'd1 : 8'd0;
                modelIdx = 1;
            end else begin
                modelSum = modelSum + {8'd0, c};
                if (c > modelMax) modelMax = c;
                if (c < modelMin) modelMin = c;
                if (c >= 4'd8) modelHi = modelHi + 8'd1;
                modelIdx++;
            end
            if (modelIdx == 4) begin
                r.sum = modelSum;
                r.mx  = modelMax;
                r.mn  = modelMin;
                r.hi  = modelHi;
                q4.push_back(r);
                modelIdx = 0;
                expOut4 = 1'b1;
            end
        end
        expBusy4 = (modelIdx != 0);
        #1;
        inValid4 = 1'b0;
        clear4   = 1'b0;
    endtask

    task automatic resetModel();
        modelIdx = 0;
        expOut4  = 1'b0;
        expBusy4 = 1'b0;
    endtask

    // Per-cycle monitor for the small instance: pulse/busy timing plus scoreboard pop
    always @(negedge clk) begin
        result_t r;
        checkOutput("out_valid4", {31'd0, outValid4}, {31'd0, expOut4});
        checkOutput("busy4", {31'd0, busy4}, {31'd0, expBusy4});
        if (outValid4 === 1'b1) begin
            if (q4.size() == 0) begin
                checkOutput("pulse4_unexpected", 32'd1, 32'd0);
            end else begin
                r = q4.pop_front();
                checkOutput("win_sum4", {20'd0, winSum4}, {20'd0, r.sum});
                checkOutput("win_max4", {28'd0, winMax4}, {28'd0, r.mx});
                checkOutput("win_min4", {28'd0, winMin4}, {28'd0, r.mn});
                checkOutput("hi_cnt4", {24'd0, hiCnt4}, {24'd0, r.hi});
            end
        end
    end

    // Monitor for the full-size instance: count pulses and pop the scoreboard
    always @(negedge clk) begin
        result_t r;
        if (outValid255 === 1'b1) begin
            pulses255++;
            if (q255.size() == 0) begin
                checkOutput("pulse255_unexpected", 32'd1, 32'd0);
            end else begin
                r = q255.pop_front();
                checkOutput("win_sum255", {20'd0, winSum255}, {20'd0, r.sum});
                checkOutput("win_max255", {28'd0, winMax255}, {28'd0, r.mx});
                checkOutput("win_min255", {28'd0, winMin255}, {28'd0, r.mn});
                checkOutput("hi_cnt255", {24'd0, hiCnt255}, {24'd0, r.hi});
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, outValid4}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy4}, 32'd0);
        checkOutput({tag, "_win_sum"}, {20'd0, winSum4}, 32'd0);
        checkOutput({tag, "_win_max"}, {28'd0, winMax4}, 32'd0);
        checkOutput({tag, "_win_min"}, {28'd0, winMin4}, 32'd0);
        checkOutput({tag, "_hi_cnt"}, {24'd0, hiCnt4}, 32'd0);
    endtask

    initial begin
        result_t r;
        logic [3:0] seq[];

        $display("[TB] start");
        #1 rst_n = 1'b0;
        #2 checkAllZero("por");
        #4 rst_n = 1'b1;

        // Basic window
        seq = '{4'd2, 4'd15, 4'd0, 4'd9};
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Back-to-back windows at full rate
        seq = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd7, 4'd7, 4'd7, 4'd7};
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Sparse boundary values with idle gaps
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd15, 1'b0);
            if (i < 3) begin
                applyStimulus(1'b0, 4'd3, 1'b0);
                applyStimulus(1'b0, 4'd3, 1'b0);
            end
        end
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Clear mid-window, discarding the sample presented with it
        applyStimulus(1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd3, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        // Clear during DONE: pulse completes, sample with clear dropped
        seq = '{4'd1, 4'd2, 4'd3, 4'd4};
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b1, 4'd6, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("hold_after_clear_sum", {20'd0, winSum4}, 32'd10);

        // Asynchronous reset in the middle of a partial window
        applyStimulus(1'b1, 4'd12, 1'b0);
        applyStimulus(1'b1, 4'd12, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkAllZero("midreset");
        resetModel();
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0);
        seq = '{4'd8, 4'd7, 4'd8, 4'd7};
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("q4_drained", q4.size(), 32'd0);

        // Maximum window: 255 samples of 15 with THRESH=0
        r.sum = 12'd3825;
        r.mx  = 4'd15;
        r.mn  = 4'd15;
        r.hi  = 8'd255;
        for (int i = 0; i < 255; i++) begin
            inValid255 = 1'b1;
            count255   = 4'd15;
            if (i == 254) q255.push_back(r);
            @(posedge clk);
            #1;
            if (i == 100) checkOutput("busy255_mid", {31'd0, busy255}, 32'd1);
        end
        inValid255 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pulses255", pulses255, 32'd1);
        checkOutput("q255_drained", q255.size(), 32'd0);
        checkOutput("busy255_end", {31'd0, busy255}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
